// File: rtl/chess_pkg.sv
// Shared chess definitions: side codes, piece codes, square/board widths.
package chess_pkg;

   localparam logic WHITE = 1'b0;
   localparam logic BLACK = 1'b1;

   localparam int unsigned SQ_W    = 6;    // square index width (0..63)
   localparam int unsigned BOARD_W = 64;   // one bit per square
   localparam int unsigned POP_W   = 7;    // popcount of a board mask (0..64)
   localparam int unsigned CNT_W   = 8;    // saturating legal-move counter

   localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(BOARD_W - 1);

   typedef enum logic [2:0] {
      PC_NONE   = 3'd0,
      PC_PAWN   = 3'd1,
      PC_KNIGHT = 3'd2,
      PC_BISHOP = 3'd3,
      PC_ROOK   = 3'd4,
      PC_QUEEN  = 3'd5,
      PC_KING   = 3'd6
   } piece_t;

   typedef logic [SQ_W-1:0]    square_t;
   typedef logic [BOARD_W-1:0] board_t;

endpackage

// File: rtl/popcount64.sv
// Combinational population count of a 64-bit board mask.
//   i_bits     : board mask
//   o_count_c  : number of set bits (0..64), combinational
module popcount64
   import chess_pkg::*;
(
   input  logic [BOARD_W-1:0] i_bits,
   output logic [POP_W-1:0]   o_count_c
);

   always_comb begin
      o_count_c = '0;
      for (int k = 0; k < BOARD_W; k++) begin
         o_count_c = o_count_c + POP_W'(i_bits[k]);
      end
   end

endmodule

// File: rtl/game_end_detector.sv
// Game-end detector: after a move, walks every square owned by the side to
// move, asks the legal-move filter for each piece's filtered destinations,
// sums the legal moves and reports checkmate / stalemate / game continues.
//   clk, reset           : clock, asynchronous active-low reset
//   start, turn          : evaluation request and side to evaluate
//   ownOccupancy         : squares holding pieces of `turn`
//   check                : per-side in-check flags, sampled at decision time
//   handlerReady         : option-filter ready
//   modifiedMoveOptions  : option-filter result mask
//   update, selected,
//   selectedPosition     : request interface towards the option filter
//   busy, done           : evaluation status
//   checkmate, stalemate,
//   legalCount           : results, held until the next accepted start
//   timeoutError         : a filter handshake exceeded TIMEOUT cycles
module game_end_detector
   import chess_pkg::*;
#(
   parameter int unsigned TIMEOUT    = 4096,
   parameter int unsigned EARLY_EXIT = 0
)
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               turn,
   input  logic [BOARD_W-1:0] ownOccupancy,
   input  logic [1:0]         check,
   input  logic               handlerReady,
   input  logic [BOARD_W-1:0] modifiedMoveOptions,
   output logic               update,
   output logic               selected,
   output logic [SQ_W-1:0]    selectedPosition,
   output logic               busy,
   output logic               done,
   output logic               checkmate,
   output logic               stalemate,
   output logic [CNT_W-1:0]   legalCount,
   output logic               timeoutError
);

   localparam int unsigned WD_W  = $clog2(TIMEOUT + 1);
   localparam int unsigned SUM_W = CNT_W + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_SCAN      = 3'd1;
   localparam logic [2:0] S_REQUEST   = 3'd2;
   localparam logic [2:0] S_WAIT_BUSY = 3'd3;
   localparam logic [2:0] S_WAIT_DONE = 3'd4;
   localparam logic [2:0] S_ACCUM     = 3'd5;
   localparam logic [2:0] S_DECIDE    = 3'd6;
   localparam logic [2:0] S_DONE      = 3'd7;

   logic [2:0]         r_state,     w_state;
   logic [SQ_W-1:0]    r_idx,       w_idx;
   logic [BOARD_W-1:0] r_occ,       w_occ;
   logic               r_turn,      w_turn;
   logic [WD_W-1:0]    r_wd,        w_wd;
   logic               r_update,    w_update;
   logic               r_selected,  w_selected;
   logic [SQ_W-1:0]    r_selpos,    w_selpos;
   logic               r_busy,      w_busy;
   logic               r_done,      w_done;
   logic               r_checkmate, w_checkmate;
   logic               r_stalemate, w_stalemate;
   logic [CNT_W-1:0]   r_count,     w_count;
   logic               r_timeout,   w_timeout;

   logic [POP_W-1:0]   w_pop;
   logic [SUM_W-1:0]   w_sum;
   logic [SQ_W-1:0]    w_idx_inc;
   logic               w_last;
   logic               w_wd_expired;
   logic               w_no_moves;

   popcount64 u_popcount (
      .i_bits    (modifiedMoveOptions),
      .o_count_c (w_pop)
   );

   // 9-bit add so the 8-bit counter can saturate instead of wrapping
   assign w_sum        = {1'b0, r_count} + SUM_W'(w_pop);
   assign w_idx_inc    = r_idx + SQ_W'(1);
   assign w_last       = (r_idx == SQ_LAST);
   assign w_wd_expired = (r_wd == WD_LAST);
   assign w_no_moves   = (r_count == '0);

   // Next-state and next-output logic
   always_comb begin
      w_state     = r_state;
      w_idx       = r_idx;
      w_occ       = r_occ;
      w_turn      = r_turn;
      w_wd        = r_wd;
      w_update    = 1'b0;
      w_selected  = r_selected;
      w_selpos    = r_selpos;
      w_busy      = r_busy;
      w_done      = 1'b0;
      w_checkmate = r_checkmate;
      w_stalemate = r_stalemate;
      w_count     = r_count;
      w_timeout   = r_timeout;

      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_state     = S_SCAN;
               w_occ       = ownOccupancy;
               w_turn      = turn;
               w_idx       = '0;
               w_busy      = 1'b1;
               w_checkmate = 1'b0;
               w_stalemate = 1'b0;
               w_count     = '0;
               w_timeout   = 1'b0;
            end
         end

         S_SCAN: begin
            // an occupied square waits here until the filter is free
            if (r_occ[r_idx]) begin
               if (handlerReady) begin
                  w_state    = S_REQUEST;
                  w_update   = 1'b1;
                  w_selected = 1'b1;
                  w_selpos   = r_idx;
               end
            end else if (w_last) begin
               w_state = S_DECIDE;
            end else begin
               w_idx = w_idx_inc;
            end
         end

         S_REQUEST: begin
            w_state = S_WAIT_BUSY;
            w_wd    = '0;
         end

         S_WAIT_BUSY, S_WAIT_DONE: begin
            w_wd = r_wd + WD_W'(1);
            if ((r_state == S_WAIT_BUSY) && !handlerReady) begin
               w_state = S_WAIT_DONE;
            end else if ((r_state == S_WAIT_DONE) && handlerReady) begin
               w_state = S_ACCUM;
            end else if (w_wd_expired) begin
               // abandon this square: it contributes no moves
               w_timeout  = 1'b1;
               w_selected = 1'b0;
               if (w_last) begin
                  w_state = S_DECIDE;
               end else begin
                  w_idx   = w_idx_inc;
                  w_state = S_SCAN;
               end
            end
         end

         S_ACCUM: begin
            w_count    = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
            w_selected = 1'b0;
            if ((EARLY_EXIT != 0) && (w_pop != '0)) begin
               w_state = S_DECIDE;
            end else if (w_last) begin
               w_state = S_DECIDE;
            end else begin
               w_idx   = w_idx_inc;
               w_state = S_SCAN;
            end
         end

         S_DECIDE: begin
            w_checkmate = w_no_moves &&  check[r_turn];
            w_stalemate = w_no_moves && !check[r_turn];
            w_done      = 1'b1;
            w_state     = S_DONE;
         end

         S_DONE: begin
            w_busy  = 1'b0;
            w_state = S_IDLE;
         end

         default: begin
            w_state = S_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_IDLE;
         r_idx       <= '0;
         r_occ       <= '0;
         r_turn      <= 1'b0;
         r_wd        <= '0;
         r_update    <= 1'b0;
         r_selected  <= 1'b0;
         r_selpos    <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_checkmate <= 1'b0;
         r_stalemate <= 1'b0;
         r_count     <= '0;
         r_timeout   <= 1'b0;
      end else begin
         r_state     <= w_state;
         r_idx       <= w_idx;
         r_occ       <= w_occ;
         r_turn      <= w_turn;
         r_wd        <= w_wd;
         r_update    <= w_update;
         r_selected  <= w_selected;
         r_selpos    <= w_selpos;
         r_busy      <= w_busy;
         r_done      <= w_done;
         r_checkmate <= w_checkmate;
         r_stalemate <= w_stalemate;
         r_count     <= w_count;
         r_timeout   <= w_timeout;
      end
   end

   assign update           = r_update;
   assign selected         = r_selected;
   assign selectedPosition = r_selpos;
   assign busy             = r_busy;
   assign done             = r_done;
   assign checkmate        = r_checkmate;
   assign stalemate        = r_stalemate;
   assign legalCount       = r_count;
   assign timeoutError     = r_timeout;

endmodule

// File: tb/tb_game_end_detector.sv
// Self-checking bench for game_end_detector with a stub option filter.
module tb_game_end_detector;

   localparam int unsigned TO = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        turn;
   logic [63:0] ownOccupancy;
   logic [1:0]  check;
   logic        handlerReady;
   logic [63:0] modifiedMoveOptions;
   logic        update;
   logic        selected;
   logic [5:0]  selectedPosition;
   logic        busy;
   logic        done;
   logic        checkmate;
   logic        stalemate;
   logic [7:0]  legalCount;
   logic        timeoutError;

   always #5 clk = ~clk;

   game_end_detector #(.TIMEOUT(TO), .EARLY_EXIT(0)) dut (
      .clk                 (clk),
      .reset               (rst_n),
      .start               (start),
      .turn                (turn),
      .ownOccupancy        (ownOccupancy),
      .check               (check),
      .handlerReady        (handlerReady),
      .modifiedMoveOptions (modifiedMoveOptions),
      .update              (update),
      .selected            (selected),
      .selectedPosition    (selectedPosition),
      .busy                (busy),
      .done                (done),
      .checkmate           (checkmate),
      .stalemate           (stalemate),
      .legalCount          (legalCount),
      .timeoutError        (timeoutError)
   );

   // Stub option filter: per-square masks come from mask_tab
   logic [63:0] mask_tab [64];
   logic        stub_hang;
   logic        stub_active;
   int          stub_cnt;
   int          req_q[$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         handlerReady        <= 1'b1;
         stub_active         <= 1'b0;
         stub_cnt            <= 0;
         modifiedMoveOptions <= 64'd0;
      end else if (update) begin
         handlerReady        <= 1'b0;
         stub_active         <= 1'b1;
         stub_cnt            <= int'($urandom_range(0, 4));
         modifiedMoveOptions <= mask_tab[selectedPosition];
         req_q.push_back(int'(selectedPosition));
      end else if (stub_active && !selected) begin
         handlerReady <= 1'b1;
         stub_active  <= 1'b0;
      end else if (stub_active && !stub_hang) begin
         if (stub_cnt == 0) begin
            handlerReady <= 1'b1;
            stub_active  <= 1'b0;
         end else begin
            stub_cnt <= stub_cnt - 1;
         end
      end
   end

   int vectors    = 0;
   int miscompares = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One evaluation; expectations derived from the rules on occ/mask_tab/check
   task automatic run_eval(input string tag, input logic [63:0] occ, input logic t,
                           input logic [1:0] ck, input logic start_on_done,
                           input logic exp_to);
      int exp_reqs[$];
      int sum;
      int got;
      logic exp_mate;
      logic exp_stale;
      sum = 0;
      for (int s = 0; s < 64; s++) begin
         if (occ[s]) begin
            exp_reqs.push_back(s);
            if (!exp_to) sum += $countones(mask_tab[s]);
         end
      end
      if (sum > 255) sum = 255;
      exp_mate  = (sum == 0) &&  ck[t];
      exp_stale = (sum == 0) && !ck[t];
      req_q.delete();

      @(negedge clk);
      ownOccupancy = occ;
      turn         = t;
      check        = ck;
      start        = 1'b1;
      @(negedge clk);
      start        = 1'b0;
      ownOccupancy = ~occ;
      turn         = ~t;
      chk({tag, ".busy_after_start"}, 64'(busy), 64'd1);

      got = 0;
      for (int c = 0; c < 5000; c++) begin
         if (done) begin
            got = 1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, ".done_seen"}, 64'(got), 64'd1);
      if (got != 0) begin
         chk({tag, ".count"},     64'(legalCount),   64'(sum));
         chk({tag, ".checkmate"}, 64'(checkmate),    64'(exp_mate));
         chk({tag, ".stalemate"}, 64'(stalemate),    64'(exp_stale));
         chk({tag, ".timeout"},   64'(timeoutError), 64'(exp_to));
         chk({tag, ".busy_on_done"}, 64'(busy), 64'd1);
         if (start_on_done) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         chk({tag, ".done_pulse"}, 64'(done), 64'd0);
         chk({tag, ".busy_after"}, 64'(busy), 64'd0);
         chk({tag, ".count_held"}, 64'(legalCount), 64'(sum));
      end

      chk({tag, ".num_reqs"}, 64'(req_q.size()), 64'(exp_reqs.size()));
      for (int k = 0; k < exp_reqs.size() && k < req_q.size(); k++) begin
         chk($sformatf("%s.req%0d", tag, k), 64'(req_q[k]), 64'(exp_reqs[k]));
      end
   endtask

   initial begin
      logic [63:0] occ;
      int          found;
      rst_n        = 1'b1;
      start        = 1'b0;
      turn         = 1'b0;
      ownOccupancy = 64'd0;
      check        = 2'b00;
      stub_hang    = 1'b0;
      for (int s = 0; s < 64; s++) mask_tab[s] = 64'd0;

      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset.outs", 64'({update, selected, selectedPosition, busy, done, checkmate,
                             stalemate, legalCount, timeoutError}), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // lone white king on a1 with three moves; start repeated on done is ignored
      mask_tab[0] = 64'h0000_0000_0000_0302;
      run_eval("king3", 64'h1, 1'b0, 2'b00, 1'b1, 1'b0);

      mask_tab[0] = 64'd0;
      run_eval("mate",  64'h1, 1'b0, 2'b01, 1'b0, 1'b0);
      run_eval("stale", 64'h1, 1'b0, 2'b00, 1'b0, 1'b0);
      run_eval("black_mate_other_chk", 64'h1, 1'b1, 2'b01, 1'b0, 1'b0);

      // 16 pieces, every mask full: count saturates
      for (int s = 0; s < 16; s++) mask_tab[s] = '1;
      run_eval("saturate", 64'hFFFF, 1'b0, 2'b00, 1'b0, 1'b0);

      run_eval("empty_board", 64'd0, 1'b1, 2'b10, 1'b0, 1'b0);

      // filter never comes back: watchdog abandons the square
      stub_hang = 1'b1;
      mask_tab[0] = '1;
      run_eval("timeout", 64'h1, 1'b0, 2'b00, 1'b0, 1'b1);
      stub_hang = 1'b0;
      repeat (2) @(negedge clk);

      // reset in the middle of a handshake
      stub_hang    = 1'b1;
      ownOccupancy = 64'h1;
      turn         = 1'b0;
      start        = 1'b1;
      @(negedge clk);
      start = 1'b0;
      found = 0;
      for (int c = 0; c < 200; c++) begin
         if (selected && !handlerReady) begin
            found = 1;
            break;
         end
         @(negedge clk);
      end
      chk("rstmid.reached_wait", 64'(found), 64'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rstmid.outs_async", 64'({update, selected, selectedPosition, busy, done, checkmate,
                                    stalemate, legalCount, timeoutError}), 64'd0);
      repeat (2) @(negedge clk);
      chk("rstmid.outs_held", 64'({update, selected, selectedPosition, busy, done, checkmate,
                                   stalemate, legalCount, timeoutError}), 64'd0);
      stub_hang = 1'b0;
      rst_n     = 1'b1;
      @(negedge clk);
      mask_tab[63] = 64'h0000_0000_00F0_0000;
      run_eval("sq63", 64'h8000_0000_0000_0000, 1'b1, 2'b11, 1'b0, 1'b0);

      // randomized positions
      for (int it = 0; it < 20; it++) begin
         if (it % 5 == 0) occ = {$urandom, $urandom};
         else             occ = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         for (int s = 0; s < 64; s++) begin
            if ((it % 3 == 0) || ($urandom_range(0, 3) == 0)) mask_tab[s] = 64'd0;
            else mask_tab[s] = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
         end
         run_eval($sformatf("rand%0d", it), occ, 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
